// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
// Used by uart_rx and the future uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs (RXD, CTS).
// Resets to 1 so an idle-high serial line never shows a false edge out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking would collapse the chain to one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop deserialiser with a one-entry valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  logic                 w_rxs;
  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [CW-1:0]        r_sample_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_cnt_wrap;
  logic                 w_cnt_clr;
  logic                 w_bits_clr;
  logic                 w_shift_en;
  logic                 w_stop_sample;
  logic                 w_par_sample;
  logic                 w_byte_ok;
  logic                 w_deliver;
  logic                 r_rx_valid;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_frame_err;
  logic                 r_overrun_err;

  uart_sync2 u_sync_rxd (
    .clk   (clk),
    .reset (reset),
    .i_d   (rxd),
    .o_q   (w_rxs)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_cnt_wrap = (r_sample_cnt == CNT_LAST);

  // NOTE: every output of this block gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_clr     = 1'b0;
    w_bits_clr    = 1'b0;
    w_shift_en    = 1'b0;
    w_stop_sample = 1'b0;
    w_par_sample  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (os_tick && !w_rxs) begin
          w_state_next = START;
          w_cnt_clr    = 1'b1;
        end
      end
      START: begin
        // Mid-bit check rejects sub-half-bit glitches on the line.
        if (os_tick && (r_sample_cnt == CNT_MID)) begin
          if (w_rxs) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = DATA;
            w_cnt_clr    = 1'b1;
            w_bits_clr   = 1'b1;
          end
        end
      end
      DATA: begin
        if (os_tick && w_cnt_wrap) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (os_tick && w_cnt_wrap) begin
          w_par_sample = 1'b1;
          w_state_next = STOP;
        end
`else
        w_state_next = IDLE;
`endif
      end
      STOP: begin
        if (os_tick && w_cnt_wrap) begin
          w_stop_sample = 1'b1;
          w_state_next  = w_rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (w_rxs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counters free-run on os_tick; the FSM only clears them at bit boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
    end else if (os_tick) begin
      if (w_cnt_clr)       r_sample_cnt <= '0;
      else if (w_cnt_wrap) r_sample_cnt <= '0;
      else                 r_sample_cnt <= r_sample_cnt + CW'(1);

      if (w_bits_clr)      r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + BW'(1);

      if (w_shift_en) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) r_par_bad <= (w_rxs != (^r_shift ^ PAR_ODD));
      r_parity_err <= w_stop_sample & r_par_bad;
    end
  end

  assign w_byte_ok  = w_rxs & ~r_par_bad;
  assign parity_err = r_parity_err;
`else
  logic w_unused_par;

  assign w_unused_par = PAR_ODD ^ w_par_sample;
  assign w_byte_ok    = w_rxs;
  assign parity_err   = 1'b0;
`endif

  assign w_deliver = w_stop_sample & w_byte_ok;

  // The output register may load in the same cycle the consumer drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_stop_sample & ~w_rxs;
      r_overrun_err <= 1'b0;
      if (w_deliver && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else begin
        if (w_deliver)              r_overrun_err <= 1'b1;
        if (r_rx_valid && rx_ready) r_rx_valid    <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven single frames plus hand-written
// glitch, break, overrun, reset-abort and (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_rx;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic          clk = 1'b0;
  logic          reset;
  logic          os_tick;
  logic          rxd;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .PARITY_ODD (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .os_tick     (os_tick),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // os_tick: one clk high every TICK_DIV clks, changed 1 time unit after posedge.
  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 os_tick = 1'b1;
      @(posedge clk);
      #1 os_tick = 1'b0;
    end
  end

  // Scoreboard: bytes expected at the handshake, popped on each transfer.
  logic [DB-1:0] exp_q[$];
  int valid_cycles = 0;
  int frame_cnt    = 0;
  int over_cnt     = 0;
  int par_cnt      = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rx_valid)    valid_cycles++;
        if (frame_err)   frame_cnt++;
        if (overrun_err) over_cnt++;
        if (parity_err)  par_cnt++;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", rx_data);
          end else begin
            check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) drive_bit(1'b1);
`endif
    drive_bit(stop);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    int            exp_valid;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int v0, f0, o0, p0;

  task automatic snap();
    v0 = valid_cycles;
    f0 = frame_cnt;
    o0 = over_cnt;
    p0 = par_cnt;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_ferr: 1};
    vecs[4] = '{data: 8'h01, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[5] = '{data: 8'h80, stop: 1'b1, exp_valid: 1, exp_ferr: 0};

    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data",     32'(rx_data),     32'h0);
    check("reset_rx_valid",    32'(rx_valid),    32'h0);
    check("reset_busy",        32'(busy),        32'h0);
    check("reset_frame_err",   32'(frame_err),   32'h0);
    check("reset_overrun_err", 32'(overrun_err), 32'h0);
    check("reset_parity_err",  32'(parity_err),  32'h0);
    reset = 1'b0;
    idle_bits(1);

    // Single frames with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      snap();
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop);
      idle_bits(2);
      check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cycles - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_frame_err", i),    32'(frame_cnt - f0),    32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_overrun", i),      32'(over_cnt - o0),     32'h0);
      check($sformatf("vec%0d_busy", i),         32'(busy),              32'h0);
    end

    // Start-bit glitch: low for 4 ticks only.
    snap();
    rxd = 1'b0;
    repeat (4 * TICK_DIV) @(posedge clk);
    #1;
    idle_bits(2);
    check("glitch_valid", 32'(valid_cycles - v0), 32'h0);
    check("glitch_errs",  32'((frame_cnt - f0) + (over_cnt - o0) + (par_cnt - p0)), 32'h0);
    check("glitch_busy",  32'(busy), 32'h0);

    // Bad stop bit followed by a held-low line, then recovery.
    snap();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (40 * BIT_CLKS) @(posedge clk);
    #1;
    check("break_frame_err", 32'(frame_cnt - f0),    32'h1);
    check("break_valid",     32'(valid_cycles - v0), 32'h0);
    check("break_busy",      32'(busy),              32'h1);
    idle_bits(2);
    check("break_exit_busy", 32'(busy), 32'h0);
    snap();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle_bits(2);
    check("after_break_valid", 32'(valid_cycles - v0), 32'h1);
    check("after_break_ferr",  32'(frame_cnt - f0),    32'h0);

    // Overrun: consumer stalled across two frames.
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, ^8'h11, 1'b1);
    idle_bits(1);
    send_frame(8'h22, ^8'h22, 1'b1);
    idle_bits(2);
    check("overrun_data",  32'(rx_data),         32'h11);
    check("overrun_valid", 32'(rx_valid),        32'h1);
    check("overrun_count", 32'(over_cnt - o0),   32'h1);
    check("overrun_ferr",  32'(frame_cnt - f0),  32'h0);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("overrun_drained_valid", 32'(rx_valid),     32'h0);
    check("overrun_queue_empty",   32'(exp_q.size()), 32'h0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    idle_bits(2);
    check("parity_bad_err",   32'(par_cnt - p0),      32'h1);
    check("parity_bad_valid", 32'(valid_cycles - v0), 32'h0);
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check("parity_good_err",   32'(par_cnt - p0),      32'h0);
    check("parity_good_valid", 32'(valid_cycles - v0), 32'h1);
`endif

    // Reset during data bit 3 aborts the frame.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1;
    check("midframe_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_rx_data",  32'(rx_data),   32'h0);
    check("abort_rx_valid", 32'(rx_valid),  32'h0);
    check("abort_busy",     32'(busy),      32'h0);
    check("abort_errs",     32'({frame_err, overrun_err, parity_err}), 32'h0);
    rxd   = 1'b1;
    reset = 1'b0;
    idle_bits(1);
    snap();
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    idle_bits(2);
    check("post_reset_valid", 32'(valid_cycles - v0), 32'h1);
    check("post_reset_errs",  32'((frame_cnt - f0) + (over_cnt - o0) + (par_cnt - p0)), 32'h0);

    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
